// File: rtl/fbram_responder.sv
// Block-RAM backed responder for the framebuffer request bus: single-word
// writes and reads, one request outstanding, fixed busy/read latencies.
module fbram_responder #(
  parameter int LINES      = 120,
  parameter int WORDS      = 80,
  parameter int WR_CYCLES  = 2,
  parameter int RD_LATENCY = 3
) (
  input  logic        clk25,
  input  logic        reset_n,
  input  logic [21:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        wr_enable,
  input  logic [21:0] rd_addr,
  input  logic        rd_enable,
  output logic [15:0] rd_data,
  output logic        rd_ready,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for a request; write wins if both enables are high
  // WRITE | write accepted, holding busy for WR_CYCLES cycles
  // READ  | read accepted, counting down to the rd_ready pulse
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  localparam int DEPTH = LINES * WORDS;
  localparam int IW    = $clog2(DEPTH);

  state_t          state;
  logic [3:0]      cnt;
  logic [IW-1:0]   rd_idx;
  logic            rd_ok;
  logic [15:0]     rd_word;
  logic [15:0]     mem [DEPTH];

  function automatic logic [IW-1:0] to_idx(input logic [21:0] a);
    return IW'(a[21:7]) * IW'(WORDS) + IW'(a[6:0]);
  endfunction

  function automatic logic in_range(input logic [21:0] a);
    return (32'(a[21:7]) < LINES) && (32'(a[6:0]) < WORDS);
  endfunction

  // Storage is never reset so contents survive a controller reset.
  always_ff @(posedge clk25) begin
    if (state == IDLE && wr_enable && in_range(wr_addr))
      mem[to_idx(wr_addr)] <= wr_data;
    rd_word <= mem[rd_idx];
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      busy     <= 1'b0;
      rd_ready <= 1'b0;
      rd_data  <= 16'h0000;
      rd_idx   <= '0;
      rd_ok    <= 1'b0;
    end else begin
      rd_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_enable) begin
            cnt   <= 4'(WR_CYCLES);
            busy  <= 1'b1;
            state <= WRITE;
          end else if (rd_enable) begin
            rd_idx <= to_idx(rd_addr);
            rd_ok  <= in_range(rd_addr);
            cnt    <= 4'(RD_LATENCY);
            busy   <= 1'b1;
            state  <= READ;
          end
        end
        WRITE: begin
          if (cnt == 4'd1) begin
            cnt   <= 4'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        READ: begin
          // rd_word has been valid since the edge after the accept.
          if (cnt == 4'd1) begin
            cnt      <= 4'd0;
            busy     <= 1'b0;
            rd_ready <= 1'b1;
            rd_data  <= rd_ok ? rd_word : 16'h0000;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fbram_responder.sv
// Directed bench for fbram_responder: default instance plus a slow-latency one.
module tb_fbram_responder;

  logic        clk25 = 1'b0;
  logic        reset_n;
  logic [21:0] wr_addr, rd_addr, w2_addr, r2_addr;
  logic [15:0] wr_data, w2_data;
  logic        wr_enable, rd_enable, w2_en, r2_en;
  logic [15:0] rd_data, rd2_data;
  logic        rd_ready, busy, rd2_ready, busy2;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  always #5 clk25 = ~clk25;

  fbram_responder dut (
    .clk25(clk25), .reset_n(reset_n),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_addr(rd_addr), .rd_enable(rd_enable),
    .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy)
  );

  fbram_responder #(.WR_CYCLES(4), .RD_LATENCY(5)) dut2 (
    .clk25(clk25), .reset_n(reset_n),
    .wr_addr(w2_addr), .wr_data(w2_data), .wr_enable(w2_en),
    .rd_addr(r2_addr), .rd_enable(r2_en),
    .rd_data(rd2_data), .rd_ready(rd2_ready), .busy(busy2)
  );

  always @(negedge clk25) if (rd_ready) pulses++;

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr1(input logic [21:0] a, input logic [15:0] d, output int width);
    wr_addr = a; wr_data = d; wr_enable = 1'b1;
    tick();
    wr_enable = 1'b0;
    width = 0;
    for (int n = 0; n < 20; n++) begin
      if (!busy) break;
      width++;
      tick();
    end
  endtask

  task automatic rd1(input logic [21:0] a, output logic [15:0] d, output int lat, output int width);
    rd_addr = a; rd_enable = 1'b1;
    tick();
    rd_enable = 1'b0;
    lat = 0; width = 0; d = 'x;
    for (int n = 1; n <= 20; n++) begin
      if (busy) width++;
      tick();
      if (rd_ready) begin
        lat = n;
        d = rd_data;
        check("busy_low_at_ready", busy, 0);
        break;
      end
    end
  endtask

  initial begin
    logic [15:0] d;
    int w, lat, rw, p0;

    reset_n = 1'b0;
    wr_addr = '0; wr_data = '0; wr_enable = 1'b0; rd_addr = '0; rd_enable = 1'b0;
    w2_addr = '0; w2_data = '0; w2_en = 1'b0; r2_addr = '0; r2_en = 1'b0;
    tick(); tick();
    check("reset_busy", busy, 0);
    check("reset_rd_ready", rd_ready, 0);
    check("reset_rd_data", rd_data, 16'h0000);
    check("reset_busy2", busy2, 0);
    reset_n = 1'b1;
    tick();

    // basic write then read
    wr1(22'h000287, 16'h0ABC, w);
    check("wr_busy_width", w, 2);
    rd1(22'h000287, d, lat, rw);
    check("rd_data_basic", d, 16'h0ABC);
    check("rd_latency", lat, 3);
    check("rd_busy_width", rw, 3);
    tick();
    check("rd_ready_one_cycle", rd_ready, 0);
    check("rd_data_held", rd_data, 16'h0ABC);

    // out-of-range writes must not alias onto valid words
    wr1(22'h000080, 16'h5555, w);
    wr1(22'h000183, 16'h1234, w);
    wr1(22'h003C00, 16'h1111, w);
    wr1(22'h000050, 16'hDEAD, w);
    check("oor_wr_busy_width", w, 2);
    wr1(22'h003BCF, 16'hF00D, w);
    rd1(22'h000080, d, lat, rw);
    check("alias_unchanged", d, 16'h5555);
    rd1(22'h003C00, d, lat, rw);
    check("oor_line_zero", d, 16'h0000);
    check("oor_line_latency", lat, 3);
    rd1(22'h000050, d, lat, rw);
    check("oor_word_zero", d, 16'h0000);
    rd1(22'h003BCF, d, lat, rw);
    check("last_word", d, 16'hF00D);

    // both enables together: write first, read accepted at E0+3
    wr_addr = 22'h000100; wr_data = 16'hBEEF; rd_addr = 22'h000100;
    wr_enable = 1'b1; rd_enable = 1'b1;
    tick();
    check("both_busy", busy, 1);
    wr_enable = 1'b0;
    lat = 0; d = 'x;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (rd_ready) begin lat = n; d = rd_data; break; end
    end
    rd_enable = 1'b0;
    check("both_latency", lat, 6);
    check("both_data", d, 16'hBEEF);
    tick();
    check("both_no_second_read", busy, 0);

    // requester-style traffic over line 0
    p0 = pulses;
    for (int i = 0; i < 80; i++) begin
      logic [15:0] v;
      v = 16'hA000 + 16'(i);
      wr1(22'(i), v, w);
    end
    for (int i = 0; i < 80; i++) begin
      logic [15:0] v;
      v = 16'hA000 + 16'(i);
      rd1(22'(i), d, lat, rw);
      check("b2b_data", d, v);
    end
    tick();
    check("b2b_pulse_count", pulses - p0, 80);

    // reset one cycle into a read
    rd_addr = 22'h000183; rd_enable = 1'b1;
    tick();
    rd_enable = 1'b0;
    tick();
    p0 = pulses;
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rd_ready", rd_ready, 0);
    check("abort_rd_data", rd_data, 16'h0000);
    tick(); tick();
    reset_n = 1'b1;
    repeat (7) tick();
    check("abort_no_pulse", pulses - p0, 0);
    rd1(22'h000183, d, lat, rw);
    check("survives_reset", d, 16'h1234);

    // slow instance: WR_CYCLES=4, RD_LATENCY=5
    w2_addr = 22'h000001; w2_data = 16'h7777; w2_en = 1'b1;
    tick();
    w2_en = 1'b0;
    w = 0;
    for (int n = 0; n < 20; n++) begin
      if (!busy2) break;
      w++;
      tick();
    end
    check("slow_wr_width", w, 4);
    r2_addr = 22'h000001; r2_en = 1'b1;
    tick();
    r2_en = 1'b0;
    lat = 0; rw = 0; d = 'x;
    for (int n = 1; n <= 20; n++) begin
      if (busy2) rw++;
      tick();
      if (rd2_ready) begin lat = n; d = rd2_data; break; end
    end
    check("slow_rd_latency", lat, 5);
    check("slow_rd_width", rw, 5);
    check("slow_rd_data", d, 16'h7777);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
